turn_signal_ctrl: RTL and testbench
===================================

// Module: turn_signal_ctrl
// PURPOSE
//  Sequencer/arbiter for the 6-lamp tail-light datapath y[5:0] = {LC,LB,LA,RA,RB,RC}.
//  Arbitrates the left, right and hazard requests, then steps the lamp pattern at a divided rate.
//  Sits between the driver switch inputs and the lamp drivers.
//  Replaces free-running per-clock stepping with a prescaled, priority-arbitrated Moore FSM.
// PARAMETERS
//  TICK_DIV  4  clock cycles per animation step (>=1); 1 = step every cycle
// PORTS
//  clk     in   1  system clock, rising edge
//  reset   in   1  asynchronous, active-low reset (0 = reset asserted)
//  left    in   1  left-turn request (level)
//  right   in   1  right-turn request (level)
//  hazard  in   1  hazard request (level)
//  y       out  6  lamps {LC,LB,LA,RA,RB,RC}, registered
//  busy    out  1  1 whenever state != IDLE, registered
//  tick    out  1  prescaler strobe, high 1 cycle when cnt == TICK_DIV-1
// BEHAVIOUR
//  - Reset (reset==0, async): cnt=0, state=IDLE, y=6'b000000, busy=0. tick=0 while reset is held.
//  - Prescaler: cnt counts 0..TICK_DIV-1 and wraps. It is free-running from reset release.
//    Width is max(1,$clog2(TICK_DIV)). tick is combinational on cnt; with TICK_DIV=1, tick is constant 1.
//  - The FSM advances only on a rising edge where tick=1; otherwise state holds.
//  - States and per-state y (Moore; y/busy are registered with the state, same edge):
//      IDLE 000000 | L1 001000 | L2 011000 | L3 111000
//      R1 000100 | R2 000110 | R3 000111 | HAZ 111111
//  - At a tick edge, from IDLE, priority is: hazard > (left&right -> HAZ) > left -> L1 > right -> R1.
//    With no request, stay in IDLE.
//  - Sequences run L1->L2->L3->IDLE and R1->R2->R3->IDLE, one step per tick.
//    HAZ->IDLE after one tick. Held requests therefore re-arm each pass.
//    The IDLE dark step always separates passes.
//  - Preemption: hazard=1 at a tick edge in any L*/R* state -> HAZ.
//    left/right changes mid-sequence are ignored until the FSM returns to IDLE.
//  - Requests are sampled only at tick edges. Pulses that fall entirely between ticks are lost (by design).
//  - Latency: a request held across a tick edge drives y on that edge (0 cycles after tick).
//    Worst case is TICK_DIV cycles after the request rises.
//  - Reset mid-sequence: immediate dark lamps, IDLE, and cnt=0.
//    After release, the first tick occurs TICK_DIV cycles later.
//  - Illegal/unused state encodings recover to IDLE at the next clock edge (not gated by tick).
// CONFIGURATION
//  BRAKE_EN defined: adds input port `brake` (1 bit, after hazard).
//    brake=1 forces the lamps of the side not being animated fully on: RA..RC in L*, LA..LC in R*.
//    In IDLE, brake=1 forces all six lamps on. In HAZ, lamps are unchanged (all on).
//    The override is applied in the same registered y update on every clock (not tick-gated).
//    The next state never depends on brake.
//  BRAKE_EN undefined: no brake port; y equals the state table exactly.
// TESTING (TICK_DIV=4, 10 ns clock)
//  1. Hold reset=0 for 3 cycles, then release with all requests 0
//     -> y=000000, busy=0; tick pulses every 4th cycle.
//  2. Set left=1 and hold it -> at successive ticks y=001000,011000,111000,000000,001000...
//     busy drops only during IDLE.
//  3. Set right=1 and left=1 together at IDLE -> HAZ: y=111111 for 4 cycles, then 000000, repeating.
//  4. With right=1 in R2, raise hazard for 1 cycle covering a tick edge -> y=111111 next; then IDLE.
//  5. Assert reset=0 mid-L2 (y=011000) -> y=000000 and busy=0 immediately, before the next clk edge.
//  6. BRAKE_EN: brake=1 in IDLE -> y=111111; with left=1 and brake=1, L2 -> y=011111;
//     drop brake -> y=011000 next clk.

Source files
------------

// File: rtl/turn_signal_ctrl.sv
// Tail-light sequencer: prescaled, priority-arbitrated Moore FSM driving y = {LC,LB,LA,RA,RB,RC}.
// Optional `define BRAKE_EN adds a brake input that lights the non-animated side.
//
// state | meaning
// IDLE  | dark step, arbitrates requests at the next tick
// L1-L3 | left sweep, one more lamp per tick
// R1-R3 | right sweep, one more lamp per tick
// HAZ   | all lamps on for one tick period
module turn_signal_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
`ifdef BRAKE_EN
  input  logic       brake,
`endif
  output logic [5:0] y,
  output logic       busy,
  output logic       tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_t;

  logic [CW-1:0] cnt;
  state_t        state;
  state_t        nxt;
  logic [5:0]    y_nxt;

  // tick is held low while in reset so that TICK_DIV=1 still reads 0 during reset
  assign tick = reset & (cnt == TC);

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (tick) begin
        if (hazard || (left && right)) nxt = HAZ;
        else if (left)                 nxt = L1;
        else if (right)                nxt = R1;
        else                           nxt = IDLE;
      end
      L1:  if (tick) nxt = hazard ? HAZ : L2;
      L2:  if (tick) nxt = hazard ? HAZ : L3;
      L3:  if (tick) nxt = hazard ? HAZ : IDLE;
      R1:  if (tick) nxt = hazard ? HAZ : R2;
      R2:  if (tick) nxt = hazard ? HAZ : R3;
      R3:  if (tick) nxt = hazard ? HAZ : IDLE;
      HAZ: if (tick) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    y_nxt = 6'b000000;
    case (nxt)
      L1:      y_nxt = 6'b001000;
      L2:      y_nxt = 6'b011000;
      L3:      y_nxt = 6'b111000;
      R1:      y_nxt = 6'b000100;
      R2:      y_nxt = 6'b000110;
      R3:      y_nxt = 6'b000111;
      HAZ:     y_nxt = 6'b111111;
      default: y_nxt = 6'b000000;
    endcase
`ifdef BRAKE_EN
    // brake fills in the side that is not being animated; HAZ is already all on
    if (brake) begin
      case (nxt)
        IDLE:         y_nxt = 6'b111111;
        L1, L2, L3:   y_nxt = y_nxt | 6'b000111;
        R1, R2, R3:   y_nxt = y_nxt | 6'b111000;
        default:      y_nxt = y_nxt;
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      state <= IDLE;
      y     <= 6'b000000;
      busy  <= 1'b0;
    end else begin
      cnt   <= (cnt == TC) ? '0 : cnt + CW'(1);
      state <= nxt;
      y     <= y_nxt;
      busy  <= (nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Self-checking bench for turn_signal_ctrl (TICK_DIV=4): directed steps plus randomized requests
// compared against a pass/step reference model.
module tb_turn_signal_ctrl;

  localparam int TD = 4;

  logic       clk;
  logic       reset;
  logic       left;
  logic       right;
  logic       hazard;
  logic       brake;
  logic [5:0] y;
  logic       busy;
  logic       tick;

  int total = 0;
  int bad   = 0;

  // reference model: mode 0 none, 1 left sweep, 2 right sweep, 3 hazard; k = lamps lit in sweep
  int cyc  = 0;
  int mode = 0;
  int k    = 0;
  bit ticked = 0;

  turn_signal_ctrl #(.TICK_DIV(TD)) dut (
    .clk    (clk),
    .reset  (reset),
    .left   (left),
    .right  (right),
    .hazard (hazard),
`ifdef BRAKE_EN
    .brake  (brake),
`endif
    .y      (y),
    .busy   (busy),
    .tick   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [5:0] exp_y();
    logic [5:0] v;
    logic       b;
`ifdef BRAKE_EN
    b = brake;
`else
    b = 1'b0;
`endif
    case (mode)
      1: v = 6'(((1 << k) - 1) << 3) | (b ? 6'b000111 : 6'b000000);
      2: v = 6'((7 << (3 - k)) & 7)  | (b ? 6'b111000 : 6'b000000);
      3: v = 6'b111111;
      default: v = b ? 6'b111111 : 6'b000000;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic advance_model();
    if (mode == 0) begin
      if (hazard || (left && right)) mode = 3;
      else if (left)  begin mode = 1; k = 1; end
      else if (right) begin mode = 2; k = 1; end
    end else if (mode == 3) begin
      mode = 0;
    end else if (hazard) begin
      mode = 3;
    end else begin
      k++;
      if (k > 3) begin mode = 0; k = 0; end
    end
  endtask

  // one clock: model update at the edge, y/busy checked 1 ns later, tick checked at the negedge
  task automatic cycle();
    bit tm;
    tm = ((cyc % TD) == TD - 1);
    @(posedge clk);
    cyc++;
    if (tm) advance_model();
    ticked = tm;
    #1;
    chk("y", {2'b00, y}, {2'b00, exp_y()});
    chk("busy", {7'd0, busy}, {7'd0, (mode != 0)});
    @(negedge clk);
    chk("tick", {7'd0, tick}, {7'd0, ((cyc % TD) == TD - 1)});
  endtask

  task automatic run_until_tick();
    bit seen;
    seen = 0;
    for (int i = 0; i < 2 * TD && !seen; i++) begin
      cycle();
      seen = ticked;
    end
    chk("tick_timeout", {7'd0, seen}, 8'd1);
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 8 && mode != 0; i++) run_until_tick();
  endtask

  initial begin
    reset = 1'b0; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_y", {2'b00, y}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_tick", {7'd0, tick}, 8'd0);

    // release and idle: tick every 4th cycle
    reset = 1'b1; cyc = 0; mode = 0; k = 0;
    repeat (8) cycle();
    chk("idle_y", {2'b00, y}, 8'h00);

    // held left sweeps repeatedly with a dark step between passes
    left = 1'b1;
    run_until_tick(); chk("l1", {2'b00, y}, 8'h08);
    run_until_tick(); chk("l2", {2'b00, y}, 8'h18);
    run_until_tick(); chk("l3", {2'b00, y}, 8'h38);
    run_until_tick(); chk("l_idle", {2'b00, y}, 8'h00);
    chk("l_idle_busy", {7'd0, busy}, 8'd0);
    run_until_tick(); chk("l1_again", {2'b00, y}, 8'h08);
    left = 1'b0;
    run_to_idle();

    // left+right together -> hazard pattern, alternating with dark
    left = 1'b1; right = 1'b1;
    run_until_tick(); chk("lr_haz", {2'b00, y}, 8'h3f);
    repeat (3) cycle();
    chk("lr_haz_hold", {2'b00, y}, 8'h3f);
    run_until_tick(); chk("lr_dark", {2'b00, y}, 8'h00);
    run_until_tick(); chk("lr_haz2", {2'b00, y}, 8'h3f);
    left = 1'b0; right = 1'b0;
    run_to_idle();

    // hazard preempts a right sweep in R2
    right = 1'b1;
    run_until_tick();
    run_until_tick(); chk("r2", {2'b00, y}, 8'h06);
    for (int i = 0; i < 2 * TD && ((cyc % TD) != TD - 1); i++) cycle();
    hazard = 1'b1;
    cycle();
    hazard = 1'b0;
    chk("preempt_haz", {2'b00, y}, 8'h3f);
    run_until_tick(); chk("preempt_idle", {2'b00, y}, 8'h00);
    run_until_tick(); chk("rearm_r1", {2'b00, y}, 8'h04);
    right = 1'b0;
    run_to_idle();

    // asynchronous reset in L2, then first tick TD cycles after release
    left = 1'b1;
    run_until_tick();
    run_until_tick(); chk("pre_rst_l2", {2'b00, y}, 8'h18);
    #2 reset = 1'b0;
    #1;
    chk("async_y", {2'b00, y}, 8'h00);
    chk("async_busy", {7'd0, busy}, 8'd0);
    chk("async_tick", {7'd0, tick}, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; cyc = 0; mode = 0; k = 0;
    repeat (TD - 1) cycle();
    chk("post_rst_wait", {2'b00, y}, 8'h00);
    cycle();
    chk("post_rst_first_tick", {7'd0, ticked}, 8'd1);
    chk("post_rst_l1", {2'b00, y}, 8'h08);
    left = 1'b0;
    run_to_idle();

`ifdef BRAKE_EN
    brake = 1'b1;
    cycle(); chk("brake_idle", {2'b00, y}, 8'h3f);
    left = 1'b1;
    run_until_tick();
    run_until_tick(); chk("brake_l2", {2'b00, y}, 8'h1f);
    brake = 1'b0;
    cycle(); chk("brake_drop", {2'b00, y}, 8'h18);
    left = 1'b0;
    run_to_idle();
`endif

    // randomized levels and short hazard pulses
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) left  = ~left;
      if ($urandom_range(0, 7) == 0) right = ~right;
      hazard = ($urandom_range(0, 11) == 0);
`ifdef BRAKE_EN
      if ($urandom_range(0, 5) == 0) brake = ~brake;
`endif
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
